// File: rtl/uart_bus_bridge.sv
// Binary-protocol UART-to-bus master: CMD, LEN, ADDR, [DATA] frames drive a req/gnt register bus.
// Optional macro UART2BUS_WR_ACK_EN: send 0x5A after the last write of a frame.
module uart_bus_bridge #(
    parameter int AW      = 16,
    parameter int DW      = 8,
    parameter int TIMEOUT = 50000
) (
    input  logic          clock_i,
    input  logic          reset_ni,
    input  logic [7:0]    rx_data_i,
    input  logic          new_rx_data_i,
    output logic [7:0]    tx_data_o,
    output logic          new_tx_data_o,
    input  logic          tx_busy_i,
    output logic [AW-1:0] int_address_o,
    output logic [DW-1:0] int_wr_data_o,
    output logic          int_write_o,
    output logic          int_read_o,
    input  logic [DW-1:0] int_rd_data_i,
    output logic          int_req_o,
    input  logic          int_gnt_i,
    output logic          frame_err_o
);

    // state    | meaning
    // IDLE     | wait for CMD byte
    // GET_LEN  | wait for LEN byte
    // GET_ADDR | collect AW/8 address bytes
    // GET_DATA | collect DW/8 bytes of one write word
    // BUS_WR   | request bus, write one word on grant
    // BUS_RD   | request bus, read one word on grant
    // RD_CAPT  | latch read data
    // TX_BYTE  | send next byte of the read word once tx is free
    // TX_WAIT  | wait for the transmitter to go idle
    // SEND_ACK | send write acknowledge (optional)
    typedef enum logic [3:0] {
        IDLE, GET_LEN, GET_ADDR, GET_DATA, BUS_WR, BUS_RD, RD_CAPT, TX_BYTE, TX_WAIT
`ifdef UART2BUS_WR_ACK_EN
        , SEND_ACK
`endif
    } state_t;

    localparam int            TW     = $clog2(TIMEOUT);
    localparam logic [TW-1:0] T_LOAD = TW'(TIMEOUT - 1);
    localparam logic [1:0]    A_LAST = 2'(AW / 8 - 1);
    localparam logic [1:0]    D_LAST = 2'(DW / 8 - 1);

    state_t          state_q, state_d;
    logic            is_rd_q, is_rd_d, fifo_q, fifo_d, req_q, req_d;
    logic            ntx_q, ntx_d, err_q, err_d;
    logic [7:0]      len_q, len_d, word_q, word_d, txd_q, txd_d;
    logic [1:0]      bcnt_q, bcnt_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [TW-1:0]   tout_q, tout_d;

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
            is_rd_q <= 1'b0;
            fifo_q  <= 1'b0;
            req_q   <= 1'b0;
            ntx_q   <= 1'b0;
            err_q   <= 1'b0;
            len_q   <= '0;
            word_q  <= '0;
            txd_q   <= '0;
            bcnt_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            tout_q  <= '0;
        end else begin
            state_q <= state_d;
            is_rd_q <= is_rd_d;
            fifo_q  <= fifo_d;
            req_q   <= req_d;
            ntx_q   <= ntx_d;
            err_q   <= err_d;
            len_q   <= len_d;
            word_q  <= word_d;
            txd_q   <= txd_d;
            bcnt_q  <= bcnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            tout_q  <= tout_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        is_rd_d     = is_rd_q;
        fifo_d      = fifo_q;
        req_d       = req_q;
        ntx_d       = 1'b0;
        err_d       = 1'b0;
        len_d       = len_q;
        word_d      = word_q;
        txd_d       = txd_q;
        bcnt_d      = bcnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        tout_d      = T_LOAD;
        int_write_o = 1'b0;
        int_read_o  = 1'b0;
        case (state_q)
            IDLE: if (new_rx_data_i) begin
                if (rx_data_i[7:4] == 4'h1 || rx_data_i[7:4] == 4'h2) begin
                    is_rd_d = (rx_data_i[7:4] == 4'h2);
                    fifo_d  = rx_data_i[0];
                    word_d  = '0;
                    bcnt_d  = '0;
                    state_d = GET_LEN;
                end else begin
                    err_d = 1'b1;
                end
            end
            GET_LEN: if (new_rx_data_i) begin
                len_d   = rx_data_i;
                state_d = GET_ADDR;
            end
            GET_ADDR: if (new_rx_data_i) begin
                addr_d = (addr_q << 8) | AW'(rx_data_i);
                if (bcnt_q == A_LAST) begin
                    bcnt_d  = '0;
                    state_d = is_rd_q ? BUS_RD : GET_DATA;
                end else begin
                    bcnt_d = bcnt_q + 2'd1;
                end
            end
            GET_DATA: if (new_rx_data_i) begin
                wdata_d = (wdata_q << 8) | DW'(rx_data_i);
                if (bcnt_q == D_LAST) begin
                    bcnt_d  = '0;
                    state_d = BUS_WR;
                end else begin
                    bcnt_d = bcnt_q + 2'd1;
                end
            end
            BUS_WR: if (int_gnt_i) begin
                int_write_o = 1'b1;
                if (word_q == len_q) begin
`ifdef UART2BUS_WR_ACK_EN
                    state_d = SEND_ACK;
`else
                    state_d = IDLE;
`endif
                end else begin
                    word_d  = word_q + 8'd1;
                    addr_d  = addr_q + AW'(!fifo_q);
                    state_d = GET_DATA;
                end
            end
            BUS_RD: if (int_gnt_i) begin
                int_read_o = 1'b1;
                state_d    = RD_CAPT;
            end
            RD_CAPT: begin
                wdata_d = int_rd_data_i;
                bcnt_d  = '0;
                state_d = TX_BYTE;
            end
            TX_BYTE: if (!tx_busy_i) begin
                txd_d   = wdata_q[DW-1 -: 8];
                wdata_d = wdata_q << 8;
                ntx_d   = 1'b1;
                state_d = TX_WAIT;
            end
            TX_WAIT: if (!tx_busy_i) begin
                if (bcnt_q == D_LAST) begin
                    bcnt_d = '0;
                    if (word_q == len_q) begin
                        state_d = IDLE;
                    end else begin
                        word_d  = word_q + 8'd1;
                        addr_d  = addr_q + AW'(!fifo_q);
                        state_d = BUS_RD;
                    end
                end else begin
                    bcnt_d  = bcnt_q + 2'd1;
                    state_d = TX_BYTE;
                end
            end
`ifdef UART2BUS_WR_ACK_EN
            SEND_ACK: if (!tx_busy_i) begin
                txd_d   = 8'h5A;
                ntx_d   = 1'b1;
                state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase

        // A byte arriving on the expiry cycle wins over the timeout.
        if ((state_q == GET_LEN || state_q == GET_ADDR || state_q == GET_DATA) && !new_rx_data_i) begin
            if (tout_q == '0) begin
                err_d   = 1'b1;
                state_d = IDLE;
            end else begin
                tout_d = tout_q - TW'(1);
            end
        end

        if (state_d == IDLE)
            req_d = 1'b0;
        else if (state_d == BUS_WR || state_d == BUS_RD)
            req_d = 1'b1;
    end

    assign tx_data_o     = txd_q;
    assign new_tx_data_o = ntx_q;
    assign frame_err_o   = err_q;
    assign int_req_o     = req_q;
    assign int_address_o = addr_q;
    assign int_wr_data_o = wdata_q;

endmodule

// File: doc/uart_bus_bridge.md
Name: uart_bus_bridge

Overview:
- Parametrised binary-protocol UART-to-bus master; next generation of the ASCII uart parser.
- Connects to the byte interface of uart_top (rx_data/new_rx_data, tx_data/new_tx_data/tx_busy) and drives the internal register-file bus with req/gnt arbitration.
- Supports configurable address and data widths, burst transfers with optional address auto-increment, and an inter-byte receive timeout.

Parameters:
AW, 16, address width in bits; multiple of 8, 8..32
DW, 8, data width in bits; 8, 16 or 32
TIMEOUT, 50000, clock cycles without a received byte before a partial frame is aborted (>=2)

Ports:
clock  input  1  global clock, rising edge
reset  input  1  asynchronous, active-low reset
rx_data  input  8  received byte from uart_top
new_rx_data  input  1  one-cycle strobe, rx_data valid
tx_data  output  8  byte to transmit
new_tx_data  output  1  one-cycle transmit strobe
tx_busy  input  1  transmitter busy
int_address  output  AW  bus address
int_wr_data  output  DW  bus write data
int_write  output  1  one-cycle write strobe
int_read  output  1  one-cycle read strobe
int_rd_data  input  DW  read data, valid the cycle after int_read
int_req  output  1  bus request
int_gnt  input  1  bus grant
frame_err  output  1  one-cycle pulse on a bad opcode or timeout

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While reset is low, all outputs are 0, the FSM is in IDLE, and all counters are 0. Asserting reset mid-frame discards the frame; no further bus or tx strobes are issued.
- Frame format: CMD, LEN, then AW/8 ADDR bytes (MSB first), then for writes only (LEN+1)*DW/8 DATA bytes (MSB first per word).
- CMD byte: [7:4]=0x1 write, 0x2 read; [0]=1 holds the address constant (FIFO port), otherwise the address increments by 1 per word, wrapping modulo 2^AW. Bits [3:1] are ignored.
- LEN byte: number of words minus 1 (0 -> 1 word, 255 -> 256 words).
- FSM states: IDLE, GET_LEN, GET_ADDR, GET_DATA, BUS_WR, BUS_RD, RD_CAPT, TX_BYTE, TX_WAIT, SEND_ACK.
- IDLE: a byte with a valid opcode -> GET_LEN. Any other byte -> frame_err pulse, stay in IDLE.
- GET_ADDR: collects AW/8 bytes. It then goes to GET_DATA for writes or BUS_RD for reads.
- GET_DATA: shifts bytes into the word register. After DW/8 bytes -> BUS_WR.
- BUS_WR: int_req=1. In the first cycle with int_gnt=1, int_write pulses for one cycle with int_address and int_wr_data stable. Then either return to GET_DATA for the next word, or, after the last word, go to SEND_ACK/IDLE.
- BUS_RD: int_req=1. The cycle int_gnt=1, int_read pulses for one cycle. RD_CAPT latches int_rd_data the next cycle. TX_BYTE then sends DW/8 bytes MSB first, and the FSM repeats for LEN+1 words before returning to IDLE.
- int_req rises on entry to the first BUS_WR/BUS_RD of a frame. It stays high until the frame completes (through all read transmission) and falls the cycle the FSM enters IDLE.
- TX handshake: new_tx_data pulses only when tx_busy=0. TX_WAIT then holds for at least one cycle and until tx_busy=0 before the next pulse. tx_data is held from the pulse until the next pulse.
- Bytes received during BUS_*/TX_* states are ignored; the host must wait for the response.
- Timeout: in GET_LEN/GET_ADDR/GET_DATA, a counter resets on each new_rx_data. When it reaches TIMEOUT-1 with no byte: frame_err pulses, the FSM goes to IDLE, and no bus access is made for the partial word.
- A new_rx_data arriving in the same cycle as the timeout expiry counts as a received byte; there is no timeout.

Optional Feature:
UART2BUS_WR_ACK_EN
- Defined: after the last write of a frame the FSM enters SEND_ACK and transmits 0x5A (TX handshake rules apply), then goes to IDLE.
- Undefined: SEND_ACK is absent and writes produce no tx traffic.

Test Plan:
- AW=16, DW=8: rx 10 00 12 34 AB, int_gnt tied 1 -> one int_write with int_address=0x1234, int_wr_data=0xAB. With the macro defined, tx 0x5A.
- AW=16, DW=16: rx 20 02 00 FE, int_rd_data=addr-derived pattern -> 3 int_read at 0x00FE, 0x00FF, 0x0100. tx 6 bytes MSB first; int_req high throughout, low after the last byte.
- rx 11 01 00 40 then bytes 55 66 -> two writes of 0x55 then 0x66, both at 0x0040 (no-increment bit).
- rx 10 00 12 then silence for TIMEOUT cycles -> frame_err pulse, no int_write. A following valid frame completes normally.
- int_gnt held 0 for 20 cycles during a write -> int_req stays 1 and no int_write. The write occurs on the first cycle int_gnt=1.
- rx 0x7F in IDLE -> frame_err pulse, no state change. Reset pulled low mid-read transmission -> all outputs 0 immediately.
